// File: rtl/sr_ff_bank_writer_if.sv
// Target-word handshake between the control side and sr_ff_bank_writer.
// The master offers tgt_data with tgt_valid; the slave accepts when tgt_ready is high.
interface sr_ff_bank_writer_if #(
  parameter int WIDTH = 8
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;

  modport master (output tgt_valid, output tgt_data, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_data, output tgt_ready);
endinterface

// File: rtl/sr_ff_bank_writer.sv
// Writer for a bank of SR flip-flops: drive S/R, settle, verify Q, retry, report done/err.
// Optional macro SR_FF_BANK_WRITER_FORCE_EN: drive every bit on each attempt, ignoring readback.
module sr_ff_bank_writer #(
  parameter int WIDTH      = 8,
  parameter int SETTLE_CYC = 1,
  parameter int MAX_RETRY  = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  sr_ff_bank_writer_if.slave                tgt,
  input  logic [WIDTH-1:0]                  q_fb,
  output logic [WIDTH-1:0]                  s_out,
  output logic [WIDTH-1:0]                  r_out,
  output logic                              done,
  output logic                              err,
  output logic [WIDTH-1:0]                  err_mask,
  output logic [$clog2(MAX_RETRY+2)-1:0]    attempts
);

  localparam int AW = $clog2(MAX_RETRY + 2);
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE,
    ERR
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [AW-1:0]    retry_q, retry_d;
  logic [CW-1:0]    settle_q, settle_d;

  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] err_mask_q, err_mask_d;
  logic [AW-1:0]    attempts_q, attempts_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             accept;
  logic [WIDTH-1:0] exc_t, exc_s, exc_r;

  assign accept = (state_q == IDLE) && tgt.tgt_valid && ready_q;

  // Excitation target is the live input on accept, the captured word on retries.
  always_comb begin
    exc_t = (state_q == IDLE) ? tgt.tgt_data : tgt_q;
`ifdef SR_FF_BANK_WRITER_FORCE_EN
    exc_s = exc_t;
    exc_r = ~exc_t;
`else
    exc_s = exc_t & ~q_fb;
    exc_r = ~exc_t & q_fb;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      retry_q    <= '0;
      settle_q   <= '0;
      s_q        <= '0;
      r_q        <= '0;
      err_mask_q <= '0;
      attempts_q <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      retry_q    <= retry_d;
      settle_q   <= settle_d;
      s_q        <= s_d;
      r_q        <= r_d;
      err_mask_q <= err_mask_d;
      attempts_q <= attempts_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    retry_d  = retry_q;
    settle_d = settle_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d   = tgt.tgt_data;
          retry_d = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        settle_d = '0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == CW'(SETTLE_CYC - 1)) state_d = CHECK;
        else                                  settle_d = settle_q + CW'(1);
      end
      CHECK: begin
        if (q_fb == tgt_q) begin
          state_d = DONE;
        end else if (retry_q < AW'(MAX_RETRY)) begin
          retry_d = retry_q + AW'(1);
          state_d = DRIVE;
        end else begin
          state_d = ERR;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: every output is registered from the upcoming state
  always_comb begin
    s_d        = '0;
    r_d        = '0;
    err_mask_d = err_mask_q;
    attempts_d = attempts_q;
    ready_d    = (state_d == IDLE);
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
    if (state_d == DRIVE) begin
      s_d = exc_s;
      r_d = exc_r;
    end
    if (accept) err_mask_d = '0;
    if (state_d == ERR) err_mask_d = q_fb ^ tgt_q;
    if ((state_d == DONE) || (state_d == ERR)) attempts_d = retry_q + AW'(1);
  end

  assign tgt.tgt_ready = ready_q;
  assign s_out         = s_q;
  assign r_out         = r_q;
  assign done          = done_q;
  assign err           = err_q;
  assign err_mask      = err_mask_q;
  assign attempts      = attempts_q;

endmodule
